// File: rtl/mux21_trio_check.sv
// mux21_trio_check
//   2:1 multiplexer implemented three ways in parallel (behavioural,
//   structural gate primitives, dataflow) plus a clocked checker that
//   compares the three results every cycle, and flags, latches and counts
//   any disagreement.
//
// Parameters
//   WIDTH     data width of D0, D1 and all Y outputs
//   CNT_W     width of the mismatch counter ERR_CNT
//
// Ports
//   CLK       in   rising-edge clock
//   RST       in   synchronous active-high reset, clears checker state only
//   D0        in   data selected when S=0
//   D1        in   data selected when S=1
//   S         in   select
//   INJ       in   fault injection: inverts bit 0 of Y_ST when 1
//   Y         out  primary output, equals Y_BH
//   Y_BH      out  behavioural mux result
//   Y_ST      out  structural mux result
//   Y_DF      out  dataflow mux result
//   MISMATCH  out  registered: results disagreed at the last edge
//   ERR       out  sticky mismatch flag
//   ERR_CNT   out  saturating count of mismatching cycles
module mux21_trio_check #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D0,
  input  logic [WIDTH-1:0] D1,
  input  logic             S,
  input  logic             INJ,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Y_BH,
  output logic [WIDTH-1:0] Y_ST,
  output logic [WIDTH-1:0] Y_DF,
  output logic             MISMATCH,
  output logic             ERR,
  output logic [CNT_W-1:0] ERR_CNT
);

  // Behavioural model
  logic [WIDTH-1:0] y_bh;

  always_comb begin
    if (S) y_bh = D1;
    else   y_bh = D0;
  end

  // Dataflow model
  logic [WIDTH-1:0] y_df;
  assign y_df = S ? D1 : D0;

  // Structural model: (D0 & ~S) | (D1 & S) per bit
  logic             s_n;
  logic [WIDTH-1:0] and0;
  logic [WIDTH-1:0] and1;
  logic [WIDTH-1:0] st_raw;
  logic [WIDTH-1:0] inj_mask;
  logic [WIDTH-1:0] y_st;

  not u_inv (s_n, S);

  genvar gi;
  for (gi = 0; gi < WIDTH; gi++) begin : g_st
    and u_and0 (and0[gi], D0[gi], s_n);
    and u_and1 (and1[gi], D1[gi], S);
    or  u_or   (st_raw[gi], and0[gi], and1[gi]);
  end

  // Built procedurally so WIDTH=1 needs no zero-length replication.
  always_comb begin
    inj_mask    = '0;
    inj_mask[0] = INJ;
  end

  assign y_st = st_raw ^ inj_mask;

  assign Y    = y_bh;
  assign Y_BH = y_bh;
  assign Y_ST = y_st;
  assign Y_DF = y_df;

  // Checker. 4-state compare so an X/Z select that splits the models is
  // caught in simulation; synthesis treats it as an ordinary inequality.
  logic             diff;
  logic             mismatch_d, mismatch_q;
  logic             err_d, err_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    diff       = (y_bh !== y_st) || (y_bh !== y_df);
    mismatch_d = diff;
    err_d      = err_q | diff;
    cnt_d      = cnt_q;
    if (diff && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      mismatch_q <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      mismatch_q <= mismatch_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign MISMATCH = mismatch_q;
  assign ERR      = err_q;
  assign ERR_CNT  = cnt_q;

endmodule

// File: tb/tb_mux21_trio_check.sv
module tb_mux21_trio_check;

  localparam int unsigned W   = 4;
  localparam int unsigned CW  = 3;
  localparam int unsigned MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [W-1:0]  d0  = '0;
  logic [W-1:0]  d1  = '0;
  logic          s   = 1'b0;
  logic          inj = 1'b0;
  logic [W-1:0]  y, y_bh, y_st, y_df;
  logic          mismatch, err;
  logic [CW-1:0] err_cnt;

  int errors = 0;
  int checks = 0;

  // Reference checker state
  int unsigned m_cnt = 0;
  bit          m_err = 1'b0;
  bit          m_mis = 1'b0;

  always #5 clk = ~clk;

  mux21_trio_check #(.WIDTH(W), .CNT_W(CW)) dut (
    .CLK(clk), .RST(rst), .D0(d0), .D1(d1), .S(s), .INJ(inj),
    .Y(y), .Y_BH(y_bh), .Y_ST(y_st), .Y_DF(y_df),
    .MISMATCH(mismatch), .ERR(err), .ERR_CNT(err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check mux outputs, then check checker state
  // just after the rising edge against the reference.
  task automatic cycle(input logic r, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sel, input logic fi);
    logic [W-1:0] mux;
    @(negedge clk);
    rst = r; d0 = a; d1 = b; s = sel; inj = fi;
    #1;
    mux = sel ? b : a;
    chk("y",    32'(y),    32'(mux));
    chk("y_bh", 32'(y_bh), 32'(mux));
    chk("y_df", 32'(y_df), 32'(mux));
    chk("y_st", 32'(y_st), 32'(mux ^ W'(fi)));
    @(posedge clk);
    // The three models can only disagree through fault injection.
    if (r) begin
      m_mis = 1'b0; m_err = 1'b0; m_cnt = 0;
    end else begin
      m_mis = fi;
      m_err = m_err | fi;
      if (fi && m_cnt < MAX) m_cnt = m_cnt + 1;
    end
    #1;
    chk("mismatch", 32'(mismatch), 32'(m_mis));
    chk("err",      32'(err),      32'(m_err));
    chk("err_cnt",  32'(err_cnt),  m_cnt);
  endtask

  initial begin
    // Reset state
    cycle(1, 4'h0, 4'h1, 0, 0);
    cycle(1, 4'h0, 4'h1, 0, 0);
    // Quiet mux, S=0
    cycle(0, 4'h0, 4'h1, 0, 0);
    // Toggle S at 10-cycle steps
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 10; j++)
        cycle(0, 4'h0, 4'h1, (k % 2) == 0, 0);
    // Wide pattern sweep
    for (int k = 0; k < 4; k++) cycle(0, 4'hA, 4'h5, k[0], 0);
    // Three injected cycles, then clear: ERR and count hold
    for (int k = 0; k < 3; k++) cycle(0, 4'h0, 4'h0, 0, 1);
    for (int k = 0; k < 3; k++) cycle(0, 4'h0, 4'h0, 0, 0);
    // Drive count into saturation and beyond
    for (int k = 0; k < 8; k++) cycle(0, 4'h3, 4'hC, k[0], 1);
    cycle(0, 4'h3, 4'hC, 1, 0);
    // Single reset edge clears everything
    cycle(1, 4'h3, 4'hC, 1, 0);
    cycle(0, 4'h3, 4'hC, 1, 0);
    // Reset mid-mismatch with INJ held
    cycle(0, 4'h0, 4'hF, 0, 1);
    cycle(0, 4'h0, 4'hF, 0, 1);
    cycle(1, 4'h0, 4'hF, 0, 1);
    cycle(0, 4'h0, 4'hF, 0, 1);
    cycle(0, 4'h0, 4'hF, 1, 0);
    // Randomized traffic
    for (int k = 0; k < 200; k++)
      cycle($urandom_range(0, 31) == 0, W'($urandom), W'($urandom),
            1'($urandom), $urandom_range(0, 3) == 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
